// File: rtl/pcie_rr_tag_alloc.sv
// pcie_rr_tag_alloc
//   Hands out 16 PCIe read-request tags in strict round-robin order and
//   retires each one once its QW_PER_REQ completion words have arrived.
//   A sticky watchdog flags requests that stay outstanding with no completion
//   traffic for TIMEOUT cycles.
//
// Ports
//   clock, reset             single clock, synchronous active-high reset
//   req_valid/req_ready      upstream read request handshake, req_addr payload
//   rr_valid/rr_ready        tagged request towards TX, rr_addr/rr_tag payload
//   rc_valid/rc_tag/rc_index completion word from RX (rc_index is ignored)
//   done_valid/done_tag      one-cycle pulse per retired tag
//   err_unexpected           one-cycle pulse per ignored completion word
//   outstanding              number of busy tags (0..16)
//   timeout                  sticky watchdog flag
module pcie_rr_tag_alloc #(
  parameter int QW_PER_REQ = 16,
  parameter int TIMEOUT    = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        rr_valid,
  input  logic        rr_ready,
  output logic [63:0] rr_addr,
  output logic [7:0]  rr_tag,
  input  logic        rc_valid,
  input  logic [7:0]  rc_tag,
  input  logic [5:0]  rc_index,
  output logic        done_valid,
  output logic [3:0]  done_tag,
  output logic        err_unexpected,
  output logic [4:0]  outstanding,
  output logic        timeout
);

  localparam int CNT_W = (QW_PER_REQ > 1) ? $clog2(QW_PER_REQ) : 1;
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QW_PER_REQ - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

  logic [15:0]      busy;
  logic [CNT_W-1:0] word_cnt [16];
  logic [3:0]       alloc_ptr;
  logic [WD_W-1:0]  watchdog;
  logic [WD_W-1:0]  watchdog_next;

  logic       accept;
  logic       rc_hit;
  logic       retire;
  logic [3:0] rc_slot;

  // rc_index is carried for debug visibility only.
  logic unused_rc_index;
  assign unused_rc_index = ^rc_index;

  assign req_ready = !reset && (!rr_valid || rr_ready) && !busy[alloc_ptr];
  assign accept    = req_valid && req_ready;

  // Tags 16..255 never exist, so the upper nibble must be zero to hit.
  assign rc_slot = rc_tag[3:0];
  assign rc_hit  = rc_valid && (rc_tag[7:4] == 4'd0) && busy[rc_slot];
  assign retire  = rc_hit && (word_cnt[rc_slot] == CNT_LAST);

  // Watchdog restarts whenever nothing is pending or completions are flowing,
  // and parks at TIMEOUT so it can never wrap back under the threshold.
  always_comb begin
    watchdog_next = watchdog;
    if ((outstanding == 5'd0) || rc_hit) begin
      watchdog_next = '0;
    end else if (watchdog != WD_MAX) begin
      watchdog_next = watchdog + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy           <= '0;
      alloc_ptr      <= '0;
      rr_valid       <= 1'b0;
      rr_addr        <= '0;
      rr_tag         <= '0;
      done_valid     <= 1'b0;
      done_tag       <= '0;
      err_unexpected <= 1'b0;
      outstanding    <= '0;
      timeout        <= 1'b0;
      watchdog       <= '0;
      for (int i = 0; i < 16; i++) begin
        word_cnt[i] <= '0;
      end
    end else begin
      done_valid     <= 1'b0;
      err_unexpected <= 1'b0;

      // A new accept reloads the presentation register even while the
      // previous one is being consumed, giving one request per cycle.
      if (accept) begin
        rr_valid        <= 1'b1;
        rr_addr         <= req_addr;
        rr_tag          <= {4'b0000, alloc_ptr};
        busy[alloc_ptr] <= 1'b1;
        alloc_ptr       <= alloc_ptr + 4'd1;
      end else if (rr_ready) begin
        rr_valid <= 1'b0;
      end

      // Accept only touches a free tag and retire only a busy one, so the
      // two busy updates can never collide on the same bit.
      if (rc_valid) begin
        if (rc_hit) begin
          if (retire) begin
            busy[rc_slot]     <= 1'b0;
            word_cnt[rc_slot] <= '0;
            done_valid        <= 1'b1;
            done_tag          <= rc_slot;
          end else begin
            word_cnt[rc_slot] <= word_cnt[rc_slot] + 1'b1;
          end
        end else begin
          err_unexpected <= 1'b1;
        end
      end

      case ({accept, retire})
        2'b10:   outstanding <= outstanding + 5'd1;
        2'b01:   outstanding <= outstanding - 5'd1;
        default: outstanding <= outstanding;
      endcase

      watchdog <= watchdog_next;
      if (watchdog_next == WD_MAX) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule
